memory_read_unit: RTL and testbench

Second memory-stage read responder. Consumes the split read requests produced by the first memory stage (up to two word-aligned accesses with byte counts), issues them in order to the data cache over a request/ready handshake, and merges the returned bytes into one right-justified 32-bit read result. While an access is outstanding it stalls upstream.

---
 rtl/memory_read_unit.sv | 134 +++++++++++++
 tb/tb_memory_read_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_read_unit.sv
// Second memory-stage read responder: issues up to two word reads to the data
// cache in order and merges the returned bytes into one right-justified word.
module memory_read_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        V,
  input  logic        RD_ADDR1_V,
  input  logic [31:0] RA_RD_ADDR1,
  input  logic [3:0]  RA_RD_SIZE1,
  input  logic        RD_ADDR2_V,
  input  logic [31:0] RA_RD_ADDR2,
  input  logic [3:0]  RA_RD_SIZE2,
  input  logic        FLUSH,
  input  logic        DC_READY,
  input  logic [31:0] DC_DATA,
  output logic        DC_REQ,
  output logic [31:0] DC_ADDR,
  output logic [31:0] RD_DATA,
  output logic        RD_DATA_V,
  output logic        STALL_OUT
);

  typedef enum logic [1:0] {IDLE, REQ1, REQ2, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] addr1, addr2;
  logic [3:0]  size1, size2;
  logic        addr2_v;
  logic [31:0] buffer, buffer_next;
  logic        accept;
  logic        load_result;
  logic [2:0]  src;
  logic [3:0]  dst;

  always_comb begin
    accept = ((state == IDLE) || (state == DONE)) && V && RD_ADDR1_V && !FLUSH;
  end

  // Next state and merge buffer; the buffer is cleared on accept, so only the
  // bytes that actually receive data are written afterwards.
  always_comb begin
    state_next  = state;
    buffer_next = buffer;
    load_result = 1'b0;
    src         = '0;
    dst         = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next  = REQ1;
          buffer_next = '0;
        end
      end
      REQ1: begin
        if (DC_READY) begin
          for (int i = 0; i < 4; i++) begin
            src = {1'b0, addr1[1:0]} + 3'(i);
            if ((4'(i) < size1) && !src[2]) begin
              buffer_next[8*i +: 8] = DC_DATA[{src[1:0], 3'b000} +: 8];
            end
          end
          state_next  = addr2_v ? REQ2 : DONE;
          load_result = !addr2_v;
        end
      end
      REQ2: begin
        if (DC_READY) begin
          for (int j = 0; j < 4; j++) begin
            dst = size1 + 4'(j);
            if ((4'(j) < size2) && (dst < 4'd4)) begin
              buffer_next[{dst[1:0], 3'b000} +: 8] = DC_DATA[8*j +: 8];
            end
          end
          state_next  = DONE;
          load_result = 1'b1;
        end
      end
      DONE: begin
        if (accept) begin
          state_next  = REQ1;
          buffer_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A flush discards any same-cycle cache response.
    if (FLUSH) begin
      state_next  = IDLE;
      buffer_next = buffer;
      load_result = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      addr1   <= '0;
      addr2   <= '0;
      size1   <= '0;
      size2   <= '0;
      addr2_v <= 1'b0;
      buffer  <= '0;
      RD_DATA <= '0;
    end else begin
      state  <= state_next;
      buffer <= buffer_next;
      if (accept) begin
        addr1   <= RA_RD_ADDR1;
        size1   <= RA_RD_SIZE1;
        addr2_v <= RD_ADDR2_V;
        addr2   <= RA_RD_ADDR2;
        size2   <= RA_RD_SIZE2;
      end
      if (load_result) begin
        RD_DATA <= buffer_next;
      end
    end
  end

  // Cache-facing outputs depend only on registered state.
  always_comb begin
    DC_REQ    = (state == REQ1) || (state == REQ2);
    STALL_OUT = (state == REQ1) || (state == REQ2);
    RD_DATA_V = (state == DONE);
    case (state)
      REQ1:    DC_ADDR = addr1 & 32'hFFFF_FFFC;
      REQ2:    DC_ADDR = addr2 & 32'hFFFF_FFFC;
      default: DC_ADDR = '0;
    endcase
  end

endmodule

// File: tb/tb_memory_read_unit.sv
// Bench for memory_read_unit: transaction-level model checked every cycle,
// plus directed reads with hand-computed results.
module tb_memory_read_unit;

  logic        CLK = 1'b0;
  logic        RST, V, RD_ADDR1_V, RD_ADDR2_V, FLUSH, DC_READY;
  logic [31:0] RA_RD_ADDR1, RA_RD_ADDR2, DC_DATA;
  logic [3:0]  RA_RD_SIZE1, RA_RD_SIZE2;
  logic        DC_REQ, RD_DATA_V, STALL_OUT;
  logic [31:0] DC_ADDR, RD_DATA;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  memory_read_unit dut (
    .CLK(CLK), .RST(RST), .V(V), .RD_ADDR1_V(RD_ADDR1_V),
    .RA_RD_ADDR1(RA_RD_ADDR1), .RA_RD_SIZE1(RA_RD_SIZE1),
    .RD_ADDR2_V(RD_ADDR2_V), .RA_RD_ADDR2(RA_RD_ADDR2),
    .RA_RD_SIZE2(RA_RD_SIZE2), .FLUSH(FLUSH), .DC_READY(DC_READY),
    .DC_DATA(DC_DATA), .DC_REQ(DC_REQ), .DC_ADDR(DC_ADDR),
    .RD_DATA(RD_DATA), .RD_DATA_V(RD_DATA_V), .STALL_OUT(STALL_OUT)
  );

  always #5 CLK = ~CLK;

  // Model state: outstanding word addresses plus what is needed to merge.
  logic [31:0] m_pend[$];
  logic [31:0] m_w1, m_w2, m_rd;
  logic [1:0]  m_off;
  logic [3:0]  m_s1, m_s2;
  bit          m_a2v, m_pulse;
  int          m_got;

  function automatic logic [31:0] byte_mask(input int n);
    if (n >= 4) return 32'hFFFF_FFFF;
    if (n <= 0) return 32'h0;
    return 32'((64'd1 << (8 * n)) - 64'd1);
  endfunction

  function automatic logic [31:0] merge_model(input logic [1:0] off, input logic [3:0] s1,
                                              input bit a2v, input logic [3:0] s2,
                                              input logic [31:0] w1, input logic [31:0] w2);
    int          n1;
    logic [31:0] p1;
    logic [63:0] p2;
    n1 = int'(s1);
    if (int'(off) + n1 > 4) n1 = 4 - int'(off);
    p1 = (w1 >> (8 * int'(off))) & byte_mask(n1);
    p2 = a2v ? ({32'h0, w2 & byte_mask(int'(s2))} << (8 * int'(s1))) : 64'h0;
    return p1 | p2[31:0];
  endfunction

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_pend.delete();
        m_pulse = 1'b0;
        m_rd    = '0;
      end else begin
        m_pulse = 1'b0;
        if (FLUSH) begin
          m_pend.delete();
        end else if (m_pend.size() > 0) begin
          if (DC_READY) begin
            if (m_got == 0) m_w1 = DC_DATA;
            else            m_w2 = DC_DATA;
            m_got++;
            void'(m_pend.pop_front());
            if (m_pend.size() == 0) begin
              m_rd    = merge_model(m_off, m_s1, m_a2v, m_s2, m_w1, m_w2);
              m_pulse = 1'b1;
            end
          end
        end else if (V && RD_ADDR1_V) begin
          m_off = RA_RD_ADDR1[1:0];
          m_s1  = RA_RD_SIZE1;
          m_s2  = RA_RD_SIZE2;
          m_a2v = RD_ADDR2_V;
          m_got = 0;
          m_w2  = '0;
          m_pend.push_back(RA_RD_ADDR1 & 32'hFFFF_FFFC);
          if (RD_ADDR2_V) m_pend.push_back(RA_RD_ADDR2 & 32'hFFFF_FFFC);
        end
      end
    end
  end

  // Compare every output against the model on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        check_output("dc_req",    32'(DC_REQ),    32'(m_pend.size() != 0));
        check_output("stall_out", 32'(STALL_OUT), 32'(m_pend.size() != 0));
        check_output("dc_addr",   DC_ADDR,        (m_pend.size() != 0) ? m_pend[0] : 32'h0);
        check_output("rd_data_v", 32'(RD_DATA_V), 32'(m_pulse));
        check_output("rd_data",   RD_DATA,        m_rd);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic apply_stimulus(input logic [31:0] a1, input logic [3:0] s1, input bit a2v,
                                input logic [31:0] a2, input logic [3:0] s2);
    V           = 1'b1;
    RD_ADDR1_V  = 1'b1;
    RA_RD_ADDR1 = a1;
    RA_RD_SIZE1 = s1;
    RD_ADDR2_V  = a2v;
    RA_RD_ADDR2 = a2;
    RA_RD_SIZE2 = s2;
  endtask

  task automatic clear_request();
    V          = 1'b0;
    RD_ADDR1_V = 1'b0;
    RD_ADDR2_V = 1'b0;
  endtask

  task automatic run_read(input string nm, input logic [31:0] a1, input logic [3:0] s1,
                          input bit a2v, input logic [31:0] a2, input logic [3:0] s2,
                          input logic [31:0] w1, input logic [31:0] w2, input int waits,
                          input logic [31:0] exp);
    apply_stimulus(a1, s1, a2v, a2, s2);
    tick();
    clear_request();
    for (int k = 0; k < waits; k++) begin
      DC_READY = 1'b0;
      DC_DATA  = 32'hDEAD_BEEF;
      check_output({nm, "_wait_req"}, 32'(DC_REQ), 32'h1);
      tick();
    end
    check_output({nm, "_addr1"}, DC_ADDR, a1 & 32'hFFFF_FFFC);
    check_output({nm, "_stall1"}, 32'(STALL_OUT), 32'h1);
    DC_READY = 1'b1;
    DC_DATA  = w1;
    tick();
    DC_READY = 1'b0;
    DC_DATA  = 32'hDEAD_BEEF;
    if (a2v) begin
      check_output({nm, "_addr2"}, DC_ADDR, a2);
      DC_READY = 1'b1;
      DC_DATA  = w2;
      tick();
      DC_READY = 1'b0;
      DC_DATA  = 32'hDEAD_BEEF;
    end
    check_output({nm, "_valid"}, 32'(RD_DATA_V), 32'h1);
    check_output({nm, "_data"}, RD_DATA, exp);
    check_output({nm, "_no_stall"}, 32'(STALL_OUT), 32'h0);
    tick();
    check_output({nm, "_pulse_end"}, 32'(RD_DATA_V), 32'h0);
    check_output({nm, "_hold"}, RD_DATA, exp);
  endtask

  initial begin
    RST = 1'b1;
    FLUSH = 1'b0;
    DC_READY = 1'b0;
    DC_DATA = '0;
    RA_RD_ADDR1 = '0;
    RA_RD_ADDR2 = '0;
    RA_RD_SIZE1 = '0;
    RA_RD_SIZE2 = '0;
    clear_request();
    #3;
    check_output("reset_dc_req", 32'(DC_REQ), 32'h0);
    check_output("reset_dc_addr", DC_ADDR, 32'h0);
    check_output("reset_rd_data", RD_DATA, 32'h0);
    check_output("reset_rd_data_v", 32'(RD_DATA_V), 32'h0);
    check_output("reset_stall", 32'(STALL_OUT), 32'h0);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    chk_en = 1'b1;

    // A response strobe with no request outstanding must be ignored.
    DC_READY = 1'b1;
    DC_DATA = 32'hFFFF_FFFF;
    tick();
    DC_READY = 1'b0;
    check_output("idle_ready_req", 32'(DC_REQ), 32'h0);
    check_output("idle_ready_valid", 32'(RD_DATA_V), 32'h0);

    run_read("aligned",   32'h1000, 4'd4, 1'b0, 32'h0,    4'd0, 32'hDDCC_BBAA, 32'h0,         0, 32'hDDCC_BBAA);
    run_read("split",     32'h2003, 4'd1, 1'b1, 32'h2004, 4'd3, 32'h4433_2211, 32'h8877_6655, 0, 32'h7766_5544);
    run_read("size0",     32'h7000, 4'd0, 1'b0, 32'h0,    4'd0, 32'h1234_5678, 32'h0,         0, 32'h0000_0000);
    run_read("past_word", 32'h7002, 4'd4, 1'b0, 32'h0,    4'd0, 32'hDDCC_BBAA, 32'h0,         0, 32'h0000_DDCC);
    run_read("drop",      32'h8001, 4'd3, 1'b1, 32'h8004, 4'd3, 32'h4433_2211, 32'h8877_6655, 1, 32'h5544_3322);
    run_read("wait",      32'h3002, 4'd1, 1'b0, 32'h0,    4'd0, 32'h00AB_0000, 32'h0,         3, 32'h0000_00AB);

    // Flush on the first response of a split read.
    apply_stimulus(32'h4001, 4'd3, 1'b1, 32'h4004, 4'd1);
    tick();
    clear_request();
    DC_READY = 1'b1;
    FLUSH = 1'b1;
    DC_DATA = 32'h1234_5678;
    tick();
    DC_READY = 1'b0;
    FLUSH = 1'b0;
    check_output("flush_req", 32'(DC_REQ), 32'h0);
    check_output("flush_valid", 32'(RD_DATA_V), 32'h0);
    check_output("flush_data_kept", RD_DATA, 32'h0000_00AB);
    tick();
    check_output("flush_no_req2", 32'(DC_REQ), 32'h0);
    check_output("flush_no_pulse", 32'(RD_DATA_V), 32'h0);

    // Back-to-back: a new request presented during the result cycle.
    apply_stimulus(32'h5000, 4'd2, 1'b0, 32'h0, 4'd0);
    tick();
    clear_request();
    DC_READY = 1'b1;
    DC_DATA = 32'h1111_2222;
    tick();
    DC_READY = 1'b0;
    check_output("b2b_first_valid", 32'(RD_DATA_V), 32'h1);
    check_output("b2b_first_data", RD_DATA, 32'h0000_2222);
    apply_stimulus(32'h6004, 4'd4, 1'b0, 32'h0, 4'd0);
    tick();
    clear_request();
    check_output("b2b_req", 32'(DC_REQ), 32'h1);
    check_output("b2b_addr", DC_ADDR, 32'h6004);
    check_output("b2b_gap", 32'(RD_DATA_V), 32'h0);
    DC_READY = 1'b1;
    DC_DATA = 32'hCAFE_F00D;
    tick();
    DC_READY = 1'b0;
    check_output("b2b_second_valid", 32'(RD_DATA_V), 32'h1);
    check_output("b2b_second_data", RD_DATA, 32'hCAFE_F00D);
    tick();

    // Asynchronous reset while the second access is pending.
    apply_stimulus(32'h9002, 4'd2, 1'b1, 32'h9004, 4'd2);
    tick();
    clear_request();
    DC_READY = 1'b1;
    DC_DATA = 32'h5566_7788;
    tick();
    DC_READY = 1'b0;
    check_output("arst_in_req2", DC_ADDR, 32'h9004);
    RST = 1'b1;
    #1;
    check_output("arst_req", 32'(DC_REQ), 32'h0);
    check_output("arst_stall", 32'(STALL_OUT), 32'h0);
    check_output("arst_data", RD_DATA, 32'h0);
    #1;
    RST = 1'b0;
    tick();
    check_output("arst_idle_req", 32'(DC_REQ), 32'h0);
    check_output("arst_idle_valid", 32'(RD_DATA_V), 32'h0);
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
